branch_predictor: RTL

- Fetch-side producer of branch predictions; it is the counterpart of the EX-stage branch comparator that generates switch_branch.
- Each cycle the IF stage looks up the fetch PC and receives a predicted direction and target.
- The EX stage returns each resolved outcome, and the block trains its tables on it.
- On a wrong prediction the block issues a registered redirect/flush to the PC mux and pipeline registers.
- Direct-mapped BHT (2-bit saturating counters) plus tagged BTB.

---
 rtl/branch_predictor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit BHT plus tagged BTB with registered mispredict redirect
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 10,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      fetch_pc,
    output logic             pred_taken,
    output logic [63:0]      pred_target,
    input  logic             resolve_valid,
    input  logic [63:0]      resolve_pc,
    input  logic             resolve_taken,
    input  logic [63:0]      resolve_target,
    input  logic             resolve_pred_taken,
    input  logic [63:0]      resolve_pred_target,
    output logic             mispredict,
    output logic [63:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [63:0]        target_q [ENTRIES];
    logic [63:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic             mispredict_q, mispredict_d;
    logic [63:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic             f_hit, r_hit, wrong;

    // Fetch PC bits above the tag and the byte offset do not take part in lookup.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_pc[63:IDX_W+TAG_W+2], fetch_pc[1:0]};

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign r_idx = resolve_pc[IDX_W+1:2];
    assign r_tag = resolve_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Zero-latency lookup from registered tables; same-cycle writes are not forwarded.
    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = f_hit && ctr_q[f_idx][1];
        pred_target = f_hit ? target_q[f_idx] : 64'b0;
    end

    // Misprediction detection, redirect selection and saturating performance counters.
    always_comb begin
        wrong = (resolve_pred_taken != resolve_taken) ||
                (resolve_taken && resolve_pred_taken && (resolve_pred_target != resolve_target));
        mispredict_d       = resolve_valid && wrong;
        redirect_pc_d      = redirect_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (resolve_valid) begin
            if (wrong) begin
                redirect_pc_d = resolve_taken ? resolve_target : resolve_pc + 64'd4;
                if (mispredict_count_q != {CNT_W{1'b1}}) begin
                    mispredict_count_d = mispredict_count_q + 1'b1;
                end
            end
            if (branch_count_q != {CNT_W{1'b1}}) begin
                branch_count_d = branch_count_q + 1'b1;
            end
        end
    end

    // Table training: hits move the counter, taken misses allocate over whatever was there.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        r_hit    = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
        if (resolve_valid) begin
            if (r_hit) begin
                if (resolve_taken) begin
                    if (ctr_q[r_idx] != 2'b11) begin
                        ctr_d[r_idx] = ctr_q[r_idx] + 2'b01;
                    end
                    target_d[r_idx] = resolve_target;
                end else if (ctr_q[r_idx] != 2'b00) begin
                    ctr_d[r_idx] = ctr_q[r_idx] - 2'b01;
                end
            end else if (resolve_taken) begin
                valid_d[r_idx]  = 1'b1;
                tag_d[r_idx]    = r_tag;
                target_d[r_idx] = resolve_target;
                ctr_d[r_idx]    = 2'b10;
            end
        end
    end

    // State registers; reset wins over any resolve arriving on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q            <= '0;
            mispredict_q       <= 1'b0;
            redirect_pc_q      <= 64'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 64'b0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            mispredict_q       <= mispredict_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
endmodule
